// File: rtl/tx_frame_packer.sv
// tx_frame_packer: frames a 20-bit payload stream as SYNC, payload, CRC-10.
// Optional macro TX_FRAME_SEQ_EN puts a 10-bit frame sequence in CRC[19:10].
module tx_frame_packer #(
    parameter int unsigned PAYLOAD_WORDS = 8,
    parameter logic [19:0] SYNC_WORD     = 20'hFA5C3,
    parameter logic [19:0] IDLE_WORD     = 20'h5A5A5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [19:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAY,
        ST_CRC
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_WORDS - 1);
    localparam logic [9:0] POLY     = 10'h233;

    state_t      state_q, state_d;
    logic [19:0] tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [9:0]  crc_q, crc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_crc_q, is_crc_d;
    logic [9:0]  hi10;
    logic        adv;

    // MSB-first CRC-10 over one 20-bit word, zero init, no final XOR
    function automatic logic [9:0] crc_next(input logic [9:0] c,
                                            input logic [19:0] d);
        logic [9:0] r;
        logic       fb;
        r = c;
        for (int i = 19; i >= 0; i--) begin
            fb = r[9] ^ d[i];
            r  = {r[8:0], 1'b0};
            if (fb) begin
                r = r ^ POLY;
            end
        end
        return r;
    endfunction

    assign adv        = tx_ready | ~tx_valid_q;
    assign s_ready    = (state_q == ST_PAY) & adv;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_done = is_crc_q & tx_valid_q & tx_ready;
    assign busy       = (state_q != ST_IDLE);

`ifdef TX_FRAME_SEQ_EN
    logic [9:0] seq_q, seq_d;

    // Frame sequence number, advances as each CRC word leaves
    always_comb begin
        seq_d = seq_q;
        if (frame_done) begin
            seq_d = seq_q + 10'd1;
        end
    end

    // Sequence register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 10'd0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign hi10 = seq_q;
`else
    assign hi10 = 10'h000;
`endif

    // Next-state and output-register load; nothing moves unless adv
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        is_crc_d   = adv ? 1'b0 : is_crc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (adv) begin
                    tx_valid_d = 1'b1;
                    if (s_valid) begin
                        tx_data_d = SYNC_WORD;
                        crc_d     = 10'd0;
                        cnt_d     = 8'd0;
                        state_d   = ST_PAY;
                    end else begin
                        tx_data_d = IDLE_WORD;
                    end
                end
            end
            ST_PAY: begin
                if (s_valid && adv) begin
                    tx_data_d  = s_data;
                    tx_valid_d = 1'b1;
                    crc_d      = crc_next(crc_q, s_data);
                    cnt_d      = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_CRC;
                    end
                end else if (adv) begin
                    tx_valid_d = 1'b0;
                end
            end
            ST_CRC: begin
                if (adv) begin
                    tx_data_d  = {hi10, crc_q};
                    tx_valid_d = 1'b1;
                    is_crc_d   = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 20'h0;
            tx_valid_q <= 1'b0;
            crc_q      <= 10'd0;
            cnt_q      <= 8'd0;
            is_crc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            is_crc_q   <= is_crc_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_packer.sv
// tb_tx_frame_packer: random and directed frames checked against a
// transfer-level model (expected word queue, CRC by polynomial division).
module tb_tx_frame_packer;

    localparam int          P    = 8;
    localparam logic [19:0] SYNC = 20'hFA5C3;
    localparam logic [19:0] IDLE = 20'h5A5A5;
    localparam logic [10:0] GEN  = 11'h633;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [19:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_done;
    logic        busy;

    tx_frame_packer #(.PAYLOAD_WORDS(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    int          pos, idle_run, gap, bubbles, frames_built;
    int          cyc_n, sync_cyc, span;
    logic [19:0] last_crc, prev_data, crc_a;
    logic        prev_stall, done_seen;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // remainder of M(x)*x^10 divided by the generator, by long division
    function automatic logic [9:0] ref_crc(input logic [19:0] w[$]);
        bit         m[$];
        logic [9:0] r;
        foreach (w[k]) for (int b = 19; b >= 0; b--) m.push_back(w[k][b]);
        repeat (10) m.push_back(1'b0);
        for (int i = 0; i < m.size() - 10; i++)
            if (m[i]) for (int j = 0; j < 11; j++) m[i+j] ^= GEN[10-j];
        for (int j = 0; j < 10; j++) r[9-j] = m[m.size()-10+j];
        return r;
    endfunction

    task automatic push_frame(input logic [19:0] w[$]);
        logic [9:0] hi;
`ifdef TX_FRAME_SEQ_EN
        hi = 10'(frames_built % 1024);
`else
        hi = 10'h000;
`endif
        exp_q.push_back(SYNC);
        foreach (w[k]) exp_q.push_back(w[k]);
        exp_q.push_back({hi, ref_crc(w)});
        frames_built++;
    endtask

    task automatic model_clear();
        exp_q.delete();
        pos = 0; idle_run = 0; frames_built = 0; prev_stall = 1'b0;
    endtask

    task automatic cyc(input logic rdy, output logic acc);
        logic        be;
        logic [19:0] ew;
        tx_ready = rdy;
        #1;
        if (prev_stall) begin
            check("hold_data", tx_data, prev_data);
            check("hold_valid", tx_valid, 1);
        end
        if (tx_valid && !tx_ready) check("frozen_sready", s_ready, 0);
        if (tx_valid) be = (pos <= P) && !(pos == 0 && tx_data == IDLE);
        else          be = (pos > 0);
        check("busy", busy, be);
        check("frame_done", frame_done,
              tx_valid && tx_ready && pos == P + 1);
        if (!tx_valid && pos > 0) bubbles++;
        if (tx_valid && tx_ready) begin
            if (pos == 0 && tx_data == IDLE) idle_run++;
            else begin
                check("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    ew = exp_q.pop_front();
                    check("word", tx_data, ew);
                end
                if (pos == 0) begin
                    gap = idle_run; idle_run = 0; sync_cyc = cyc_n;
                end
                pos++;
                if (pos == P + 2) begin
                    pos = 0; last_crc = tx_data; span = cyc_n - sync_cyc;
                end
            end
        end
        done_seen  = frame_done;
        acc        = s_valid && s_ready;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random
    task automatic send_frame(input logic [19:0] w[$], input int mode,
                              input int starve_at, input int abort_after,
                              input bit b2b);
        int   idx = 0, st = 0, n = 0;
        logic rdy, acc;
        bit   done = 0;
        push_frame(w);
        bubbles = 0;
        while (!done && n < 400) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (n % 2 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            if (idx < P && idx == starve_at && st < 3) begin
                s_valid = 1'b0; st++;
            end else if (idx < P) begin
                s_valid = 1'b1; s_data = w[idx];
            end else begin
                s_valid = b2b; s_data = 20'($urandom);
            end
            cyc(rdy, acc);
            if (acc) idx++;
            if (done_seen) done = 1;
            if (abort_after > 0 && idx == abort_after) return;
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $error("FAIL frame_timeout observed=%0d expected=done", n);
        end
        s_valid = b2b;
    endtask

    task automatic rand_words(output logic [19:0] w[$]);
        w.delete();
        repeat (P) w.push_back(20'($urandom));
    endtask

    task automatic reset_outputs_check();
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        logic [19:0] wa[$], wz[$];
        logic        acc;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; tx_ready = 1'b1;
        cyc_n = 0; last_crc = '0; prev_data = '0; done_seen = 1'b0;
        gap = 0; span = 0; bubbles = 0; sync_cyc = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        reset_outputs_check();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, acc);
        #1;
        check("first_valid", tx_valid, 1);
        check("first_idle", tx_data, IDLE);
        @(negedge clk);

        rand_words(wa);
        send_frame(wa, 0, -1, 0, 0);
        crc_a = last_crc;
        check("contig_span", span, P + 1);
        send_frame(wa, 1, -1, 0, 0);
        check("bp_crc_same", last_crc[9:0], crc_a[9:0]);
        send_frame(wa, 0, 3, 0, 0);
        check("starve_bubbles", bubbles, 3);
        check("starve_crc_same", last_crc[9:0], crc_a[9:0]);
        check("starve_span", span, P + 4);

        wz.delete();
        repeat (P) wz.push_back(20'h0);
        send_frame(wz, 0, -1, 0, 0);
        check("zero_crc", last_crc[9:0], 0);
        check("zero_span", span, P + 1);
        wz[P-1] = 20'h00001;
        send_frame(wz, 0, -1, 0, 0);
        check("vec_crc", last_crc[9:0], 10'h233);

        for (int f = 0; f < 6; f++) begin
            rand_words(wa);
            send_frame(wa, 2, -1, 0, f < 5);
        end

        rand_words(wa);
        send_frame(wa, 0, -1, 3, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_outputs_check();
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        rand_words(wa);
        send_frame(wa, 0, -1, 0, 1);
`ifdef TX_FRAME_SEQ_EN
        check("seq_first", last_crc[19:10], 0);
`endif
        rand_words(wa);
        send_frame(wa, 0, -1, 0, 0);
        check("b2b_gap", gap, 0);
`ifdef TX_FRAME_SEQ_EN
        check("seq_second", last_crc[19:10], 1);
        while (frames_built % 1024 != 0) begin
            rand_words(wa);
            send_frame(wa, 0, -1, 0, 1);
        end
        rand_words(wa);
        send_frame(wa, 0, -1, 0, 0);
        check("seq_wrap", last_crc[19:10], 0);
`endif
        repeat (3) cyc(1'b1, acc);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
